// File: rtl/activity_window_ctrl_if.sv
// Signal bundle between the activity-window controller and its host:
// the host drives start/abort/win_len/sig, and the controller returns status and results.
interface activity_window_ctrl_if #(
  parameter int SIG_W = 3,
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] win_len;
  logic [SIG_W-1:0] sig;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] toggle_cnt;
  logic [WIN_W-1:0] cycle_cnt;
  logic             sat;

  modport master (
    output start, abort, win_len, sig,
    input  busy, done, toggle_cnt, cycle_cnt, sat
  );

  modport slave (
    input  start, abort, win_len, sig,
    output busy, done, toggle_cnt, cycle_cnt, sat
  );
endinterface

// File: rtl/activity_window_ctrl.sv
// Measurement-window controller: counts bit toggles on a monitored bundle
// for a programmed number of cycles, with a saturating accumulator.
module activity_window_ctrl #(
  parameter int SIG_W = 3,
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  activity_window_ctrl_if.slave bus
);

  localparam int POP_W = $clog2(SIG_W + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic             sat_q, sat_d;
  logic [SIG_W-1:0] prev_q, prev_d;

  logic [SIG_W-1:0] diff;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic [WIN_W-1:0] cyc_inc;

  always_comb begin
    diff = bus.sig ^ prev_q;
    pop  = '0;
    for (int unsigned i = 0; i < SIG_W; i++) begin
      pop = pop + POP_W'(diff[i]);
    end
    // One extra bit of headroom lets the carry flag the clamp without wrapping.
    sum     = {1'b0, tog_q} + SUM_W'(pop);
    cyc_inc = cyc_q + WIN_W'(1);
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cyc_d   = cyc_q;
    tog_d   = tog_q;
    sat_d   = sat_q;
    prev_d  = prev_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d   = bus.win_len;
          tog_d   = '0;
          cyc_d   = '0;
          sat_d   = 1'b0;
          state_d = (bus.win_len == '0) ? DONE : ARM;
        end
      end
      ARM: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          prev_d  = bus.sig;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          if (sum[CNT_W]) begin
            tog_d = '1;
            sat_d = 1'b1;
          end else begin
            tog_d = sum[CNT_W-1:0];
          end
          prev_d = bus.sig;
          cyc_d  = cyc_inc;
          if (cyc_inc == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cyc_q   <= '0;
      tog_q   <= '0;
      sat_q   <= 1'b0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cyc_q   <= cyc_d;
      tog_q   <= tog_d;
      sat_q   <= sat_d;
      prev_q  <= prev_d;
    end
  end

  assign bus.busy       = (state_q == ARM) || (state_q == MEASURE);
  assign bus.done       = (state_q == DONE);
  assign bus.toggle_cnt = tog_q;
  assign bus.cycle_cnt  = cyc_q;
  assign bus.sat        = sat_q;

endmodule

// File: tb/tb_activity_window_ctrl.sv
// Directed bench for activity_window_ctrl; a second instance with a 4-bit
// accumulator exercises saturation.
module tb_activity_window_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  activity_window_ctrl_if #(.SIG_W(3), .WIN_W(16), .CNT_W(16)) bus  ();
  activity_window_ctrl_if #(.SIG_W(3), .WIN_W(16), .CNT_W(4))  bus4 ();

  activity_window_ctrl #(.SIG_W(3), .WIN_W(16), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  activity_window_ctrl #(.SIG_W(3), .WIN_W(16), .CNT_W(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.win_len = 16'd4;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
      n_cmp++; if (bus.toggle_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_tog: got %0d want 0", bus.toggle_cnt); end
      n_cmp++; if (bus.cycle_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cyc: got %0d want 0", bus.cycle_cnt); end
      n_cmp++; if (bus.sat !== 1'b0) begin n_bad++; $display("FAIL rst_sat: got %b want 0", bus.sat); end
    end
    bus.start = 1'b0; reset = 1'b0;
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_basic();
    logic [2:0] seq [4];
    logic [15:0] exp_tog [4];
    seq = '{3'b001, 3'b011, 3'b011, 3'b100};
    exp_tog = '{16'd1, 16'd2, 16'd2, 16'd5};
    bus.win_len = 16'd4; bus.start = 1'b1; bus.sig = 3'b000;
    tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_arm: got %b want 1", bus.busy); end
    bus.start = 1'b0; bus.win_len = 16'd1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.sig = seq[i];
      tick();
      n_cmp++; if (bus.toggle_cnt !== exp_tog[i]) begin n_bad++; $display("FAIL basic_tog%0d: got %0d want %0d", i, bus.toggle_cnt, exp_tog[i]); end
      n_cmp++; if (bus.cycle_cnt !== 16'(i + 1)) begin n_bad++; $display("FAIL basic_cyc%0d: got %0d want %0d", i, bus.cycle_cnt, i + 1); end
      n_cmp++; if (bus.done !== (i == 3)) begin n_bad++; $display("FAIL basic_done%0d: got %b want %b", i, bus.done, i == 3); end
    end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b want 0", bus.busy); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
    n_cmp++; if (bus.toggle_cnt !== 16'd5) begin n_bad++; $display("FAIL basic_hold: got %0d want 5", bus.toggle_cnt); end
  endtask

  task automatic test_zero_window();
    bus.win_len = 16'd0; bus.start = 1'b1;
    tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.toggle_cnt !== 16'd0) begin n_bad++; $display("FAIL zero_tog: got %0d want 0", bus.toggle_cnt); end
    n_cmp++; if (bus.cycle_cnt !== 16'd0) begin n_bad++; $display("FAIL zero_cyc: got %0d want 0", bus.cycle_cnt); end
  endtask

  task automatic test_back_to_back();
    // start still held from the zero window: ignored in DONE, accepted in IDLE.
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_ignored: got %b want 0", bus.done); end
    tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_again: got %b want 1", bus.done); end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    bus4.win_len = 16'd8; bus4.start = 1'b1; bus4.sig = 3'b000;
    tick();
    bus4.start = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus4.sig = (i % 2 == 0) ? 3'b111 : 3'b000;
      tick();
      if (i == 4) begin
        n_cmp++; if (bus4.toggle_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_tog5: got %0d want 15", bus4.toggle_cnt); end
        n_cmp++; if (bus4.sat !== 1'b0) begin n_bad++; $display("FAIL sat_flag5: got %b want 0", bus4.sat); end
      end
    end
    n_cmp++; if (bus4.done !== 1'b1) begin n_bad++; $display("FAIL sat_done: got %b want 1", bus4.done); end
    n_cmp++; if (bus4.toggle_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_tog: got %0d want 15", bus4.toggle_cnt); end
    n_cmp++; if (bus4.sat !== 1'b1) begin n_bad++; $display("FAIL sat_flag: got %b want 1", bus4.sat); end
    tick();
    n_cmp++; if (bus4.sat !== 1'b1) begin n_bad++; $display("FAIL sat_hold: got %b want 1", bus4.sat); end
    bus4.win_len = 16'd0; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    n_cmp++; if (bus4.sat !== 1'b0) begin n_bad++; $display("FAIL sat_clear: got %b want 0", bus4.sat); end
    tick();
  endtask

  task automatic test_abort();
    bus.win_len = 16'd10; bus.start = 1'b1; bus.sig = 3'b000;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++; if (bus.cycle_cnt !== 16'd2) begin n_bad++; $display("FAIL abort_ignore_start: got %0d want 2", bus.cycle_cnt); end
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.cycle_cnt !== 16'd3) begin n_bad++; $display("FAIL abort_cyc: got %0d want 3", bus.cycle_cnt); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", bus.done); end
    bus.win_len = 16'd2; bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL abort_start_wins: got %b want 1", bus.busy); end
    tick();
    tick();
    tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL abort_restart_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.cycle_cnt !== 16'd2) begin n_bad++; $display("FAIL abort_restart_cyc: got %0d want 2", bus.cycle_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_window();
    bus.win_len = 16'd5; bus.start = 1'b1; bus.sig = 3'b000;
    tick();
    bus.start = 1'b0;
    tick();
    bus.sig = 3'b111;
    tick();
    n_cmp++; if (bus.toggle_cnt !== 16'd3) begin n_bad++; $display("FAIL midrst_pre_tog: got %0d want 3", bus.toggle_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.toggle_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_tog: got %0d want 0", bus.toggle_cnt); end
    n_cmp++; if (bus.cycle_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_cyc: got %0d want 0", bus.cycle_cnt); end
    bus.sig = 3'b000; bus.win_len = 16'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.sig = 3'b010;
    tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL midrst_new_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.toggle_cnt !== 16'd1) begin n_bad++; $display("FAIL midrst_new_tog: got %0d want 1", bus.toggle_cnt); end
    n_cmp++; if (bus.cycle_cnt !== 16'd1) begin n_bad++; $display("FAIL midrst_new_cyc: got %0d want 1", bus.cycle_cnt); end
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.win_len = '0;  bus.sig = '0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.win_len = '0; bus4.sig = '0;
    test_reset();
    test_basic();
    test_zero_window();
    test_back_to_back();
    test_saturation();
    test_abort();
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
